// File: rtl/lowentropy_codebook_ctrl.sv
// Prefix sequencer for one low-entropy codebook: builds the symbol prefix, emits codewords or raw flushes.
// Optional CODEBOOK_STATS_EN adds 32-bit emitted-code and emitted-bit counters.
module lowentropy_codebook_ctrl #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int AP_CNT_MAX          = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sym_valid_i,
    input  logic [3:0]                     sym_i,
    output logic                           sym_ready_o,
    input  logic                           flush_i,
    output logic                           flush_done_o,
    output logic [5:0]                     cb_ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] cb_ap_data_o,
    input  logic                           cb_match_i,
    input  logic [5:0]                     cb_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
    output logic                           code_valid_o,
    input  logic                           code_ready_i,
    output logic [5:0]                     code_length_o,
    output logic [ENCODE_DATALENGTH-1:0]   code_data_o,
    output logic                           code_flush_o,
    output logic                           err_o
`ifdef CODEBOOK_STATS_EN
    ,
    output logic [31:0]                    stat_codes_o,
    output logic [31:0]                    stat_bits_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EMIT   = 3'd2,
        S_FLUSH  = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                          state, state_nxt;
    logic [5:0]                      ap_cnt;
    logic [CODEBOOK_LENGTH_MAX-1:0]  ap_data;
    logic                            sym_take;
    logic                            ap_clr;

    // Codebook results captured during LOOKUP, presented during EMIT.
    logic [5:0]                      code_length_p1;
    logic [ENCODE_DATALENGTH-1:0]    code_data_p1;

    assign cb_ap_cnt_o  = ap_cnt;
    assign cb_ap_data_o = ap_data;
    assign sym_take     = (state == S_IDLE) && sym_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ap_cnt  <= '0;
            ap_data <= '0;
        end else begin
            state <= state_nxt;
            if (ap_clr) begin
                ap_cnt  <= '0;
                ap_data <= '0;
            end else if (sym_take) begin
                ap_cnt  <= ap_cnt + 6'd1;
                ap_data <= {ap_data[CODEBOOK_LENGTH_MAX-5:0], sym_i};
            end
        end
    end

    // Stage p1: codebook lookup result registered
    always_ff @(posedge clk_i) begin
        if (state == S_LOOKUP) begin
            code_length_p1 <= cb_length_i;
            code_data_p1   <= cb_data_i;
        end
    end

    always_comb begin
        state_nxt     = state;
        sym_ready_o   = 1'b0;
        code_valid_o  = 1'b0;
        code_flush_o  = 1'b0;
        flush_done_o  = 1'b0;
        code_length_o = '0;
        code_data_o   = '0;
        err_o         = 1'b0;
        ap_clr        = 1'b0;
        case (state)
            S_IDLE: begin
                sym_ready_o = 1'b1;
                if (sym_valid_i) begin
                    state_nxt = S_LOOKUP;
                end else if (flush_i) begin
                    if (ap_cnt == 6'd0) flush_done_o = 1'b1;
                    else                state_nxt    = S_FLUSH;
                end
            end
            S_LOOKUP: begin
                if (cb_match_i)                    state_nxt = S_EMIT;
                else if (ap_cnt == 6'(AP_CNT_MAX)) state_nxt = S_ERR;
                else                               state_nxt = S_IDLE;
            end
            S_EMIT: begin
                code_valid_o  = 1'b1;
                code_length_o = code_length_p1;
                code_data_o   = code_data_p1;
                if (code_ready_i) begin
                    ap_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                // Raw prefix goes out as-is: 4 bits per pending symbol.
                code_valid_o  = 1'b1;
                code_flush_o  = 1'b1;
                code_length_o = ap_cnt << 2;
                code_data_o   = ENCODE_DATALENGTH'(ap_data[4*AP_CNT_MAX-1:0]);
                if (code_ready_i) begin
                    ap_clr       = 1'b1;
                    flush_done_o = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            S_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef CODEBOOK_STATS_EN
    logic [31:0] stat_codes_q;
    logic [31:0] stat_bits_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_codes_q <= '0;
            stat_bits_q  <= '0;
        end else if (code_valid_o && code_ready_i) begin
            if (!code_flush_o) stat_codes_q <= stat_codes_q + 32'd1;
            stat_bits_q <= stat_bits_q + 32'(code_length_o);
        end
    end

    assign stat_codes_o = stat_codes_q;
    assign stat_bits_o  = stat_bits_q;
`endif

endmodule

// File: tb/tb_lowentropy_codebook_ctrl.sv
// Bench for lowentropy_codebook_ctrl: directed steps then random symbols/flushes against a prefix-queue model.
module tb_lowentropy_codebook_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_valid = 1'b0;
    logic [3:0]  sym = 4'd0;
    logic        sym_ready;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [5:0]  cb_ap_cnt;
    logic [63:0] cb_ap_data;
    logic        cb_match;
    logic [5:0]  cb_length;
    logic [20:0] cb_data;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic [5:0]  code_length;
    logic [20:0] code_data;
    logic        code_flush;
    logic        err;
`ifdef CODEBOOK_STATS_EN
    logic [31:0] stat_codes;
    logic [31:0] stat_bits;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: pending prefix as a number plus its symbol count.
    int          m_cnt = 0;
    logic [63:0] m_pfx = '0;
    bit          m_err = 1'b0;
    int          m_codes = 0;
    int          m_bits = 0;

    logic [3:0] pool [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hA, 4'hB, 4'hC};

    typedef struct packed {
        logic        m;
        logic [5:0]  len;
        logic [20:0] code;
    } cb_t;

    always #5 clk = ~clk;

    lowentropy_codebook_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sym_valid_i  (sym_valid),
        .sym_i        (sym),
        .sym_ready_o  (sym_ready),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .cb_ap_cnt_o  (cb_ap_cnt),
        .cb_ap_data_o (cb_ap_data),
        .cb_match_i   (cb_match),
        .cb_length_i  (cb_length),
        .cb_data_i    (cb_data),
        .code_valid_o (code_valid),
        .code_ready_i (code_ready),
        .code_length_o(code_length),
        .code_data_o  (code_data),
        .code_flush_o (code_flush),
        .err_o        (err)
`ifdef CODEBOOK_STATS_EN
        ,
        .stat_codes_o (stat_codes),
        .stat_bits_o  (stat_bits)
`endif
    );

    // Codebook contents: (symbol count, prefix) -> (length, codeword).
    function automatic cb_t cb_lookup(input int cnt, input logic [63:0] pfx);
        cb_t r;
        r = '0;
        if      (cnt == 1 && pfx == 64'h3)   r = '{1'b1, 6'd3,  21'b000};
        else if (cnt == 1 && pfx == 64'h5)   r = '{1'b1, 6'd2,  21'b10};
        else if (cnt == 2 && pfx == 64'h01)  r = '{1'b1, 6'd5,  21'b01110};
        else if (cnt == 2 && pfx == 64'h72)  r = '{1'b1, 6'd6,  21'b110011};
        else if (cnt == 2 && pfx == 64'h44)  r = '{1'b1, 6'd21, 21'h1ABCDE};
        else if (cnt == 3 && pfx == 64'h130) r = '{1'b1, 6'd8,  21'b11100001};
        else if (cnt == 3 && pfx == 64'hABC) r = '{1'b1, 6'd12, 21'hF0F};
        else if (cnt == 3 && pfx == 64'h777) r = '{1'b1, 6'd9,  21'h1FF};
        return r;
    endfunction

    always_comb begin
        cb_t r;
        r         = cb_lookup(int'(cb_ap_cnt), cb_ap_data);
        cb_match  = r.m;
        cb_length = r.len;
        cb_data   = r.code;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_pfx = '0;
        m_err = 1'b0;
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        m_codes = 0;
        m_bits  = 0;
        @(negedge clk);
        chk("rst_ready", 64'(sym_ready), 64'd1);
        chk("rst_valid", 64'(code_valid), 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        chk("rst_cnt",   64'(cb_ap_cnt), 64'd0);
        chk("rst_data",  cb_ap_data, 64'd0);
        chk("rst_fdone", 64'(flush_done), 64'd0);
    endtask

    task automatic do_symbol(input logic [3:0] s, input int hold);
        cb_t r;
        sym_valid = 1'b1;
        sym       = s;
        #1 chk("sym_ready_idle", 64'(sym_ready), 64'd1);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        m_cnt++;
        m_pfx = m_pfx * 16 + 64'(s);
        r = cb_lookup(m_cnt, m_pfx);
        @(negedge clk);
        chk("lookup_cnt",   64'(cb_ap_cnt), 64'(m_cnt));
        chk("lookup_data",  cb_ap_data, m_pfx);
        chk("lookup_valid", 64'(code_valid), 64'd0);
        chk("lookup_ready", 64'(sym_ready), 64'd0);
        @(negedge clk);
        if (r.m) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_valid", 64'(code_valid), 64'd1);
                chk("hold_len",   64'(code_length), 64'(r.len));
                chk("hold_data",  64'(code_data), 64'(r.code));
                chk("hold_ready", 64'(sym_ready), 64'd0);
                @(negedge clk);
            end
            chk("emit_valid", 64'(code_valid), 64'd1);
            chk("emit_len",   64'(code_length), 64'(r.len));
            chk("emit_data",  64'(code_data), 64'(r.code));
            chk("emit_flush", 64'(code_flush), 64'd0);
            code_ready = 1'b1;
            #1 chk("emit_fdone", 64'(flush_done), 64'd0);
            @(posedge clk); #1;
            code_ready = 1'b0;
            m_cnt = 0;
            m_pfx = '0;
            m_codes++;
            m_bits += int'(r.len);
            @(negedge clk);
            chk("post_valid", 64'(code_valid), 64'd0);
            chk("post_cnt",   64'(cb_ap_cnt), 64'd0);
            chk("post_ready", 64'(sym_ready), 64'd1);
        end else if (m_cnt == 3) begin
            m_err = 1'b1;
            chk("err_set",   64'(err), 64'd1);
            chk("err_ready", 64'(sym_ready), 64'd0);
            chk("err_valid", 64'(code_valid), 64'd0);
        end else begin
            chk("miss_ready", 64'(sym_ready), 64'd1);
            chk("miss_valid", 64'(code_valid), 64'd0);
            chk("miss_err",   64'(err), 64'd0);
            chk("miss_cnt",   64'(cb_ap_cnt), 64'(m_cnt));
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        if (m_cnt == 0) begin
            chk("eflush_fdone", 64'(flush_done), 64'd1);
            chk("eflush_valid", 64'(code_valid), 64'd0);
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            chk("eflush_after", 64'(flush_done), 64'd0);
            chk("eflush_ready", 64'(sym_ready), 64'd1);
        end else begin
            chk("flush_early", 64'(flush_done), 64'd0);
            @(negedge clk);
            chk("flush_valid", 64'(code_valid), 64'd1);
            chk("flush_flag",  64'(code_flush), 64'd1);
            chk("flush_len",   64'(code_length), 64'(4 * m_cnt));
            chk("flush_data",  64'(code_data), m_pfx);
            chk("flush_ready", 64'(sym_ready), 64'd0);
            chk("flush_wait",  64'(flush_done), 64'd0);
            code_ready = 1'b1;
            #1 chk("flush_fdone", 64'(flush_done), 64'd1);
            @(posedge clk); #1;
            flush      = 1'b0;
            code_ready = 1'b0;
            m_bits += 4 * m_cnt;
            m_cnt = 0;
            m_pfx = '0;
            @(negedge clk);
            chk("flush_post_valid", 64'(code_valid), 64'd0);
            chk("flush_post_cnt",   64'(cb_ap_cnt), 64'd0);
            chk("flush_post_ready", 64'(sym_ready), 64'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        do_symbol(4'h3, 0);
        do_symbol(4'h0, 0);
        do_symbol(4'h1, 0);
        do_symbol(4'h1, 0);
        do_symbol(4'h3, 0);
        do_symbol(4'h0, 5);

        // Error path: sticky until reset, symbols and flushes ignored.
        do_symbol(4'h0, 0);
        do_symbol(4'hB, 0);
        do_symbol(4'hB, 0);
        sym_valid = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_sticky", 64'(err), 64'd1);
            chk("err_noready", 64'(sym_ready), 64'd0);
            chk("err_cnt", 64'(cb_ap_cnt), 64'd3);
            chk("err_fdone", 64'(flush_done), 64'd0);
        end
        sym_valid = 1'b0;
        flush     = 1'b0;
        do_reset();

        do_symbol(4'h2, 0);
        do_flush();
        do_flush();

        // Symbol and flush together: symbol first, then an empty flush.
        sym_valid = 1'b1;
        sym       = 4'h3;
        flush     = 1'b1;
        #1 chk("prio_fdone", 64'(flush_done), 64'd0);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        chk("prio_lookup_fdone", 64'(flush_done), 64'd0);
        @(negedge clk);
        chk("prio_emit_valid", 64'(code_valid), 64'd1);
        chk("prio_emit_len", 64'(code_length), 64'd3);
        chk("prio_emit_flush", 64'(code_flush), 64'd0);
        chk("prio_emit_fdone", 64'(flush_done), 64'd0);
        code_ready = 1'b1;
        @(posedge clk); #1;
        code_ready = 1'b0;
        m_codes++;
        m_bits += 3;
        @(negedge clk);
        chk("prio_after_valid", 64'(code_valid), 64'd0);
        chk("prio_after_fdone", 64'(flush_done), 64'd1);
        flush = 1'b0;
        #1 chk("prio_fdone_drop", 64'(flush_done), 64'd0);

        // Reset while a codeword is pending.
        @(negedge clk);
        sym_valid = 1'b1;
        sym       = 4'h5;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midemit_valid", 64'(code_valid), 64'd1);
        chk("midemit_len", 64'(code_length), 64'd2);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            if (m_err) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                do_flush();
            end else begin
                logic [3:0] s;
                s = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
                do_symbol(s, int'($urandom_range(0, 2)));
            end
        end

`ifdef CODEBOOK_STATS_EN
        chk("stat_codes", 64'(stat_codes), 64'(m_codes));
        chk("stat_bits", 64'(stat_bits), 64'(m_bits));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
